noc_vc_credit_scheduler: RTL and testbench

- Per-output-port virtual-channel scheduler for the NoC router.
- Shares one output link among VC_NUM input VC queues using round-robin arbitration.
- Tracks per-VC downstream buffer credits and forwards a flit only when the selected VC has a credit.
- Keeps wormhole packets atomic: a granted VC holds the link until its last flit.
- Sits between the router's VC input buffers and the link/flow-control stage.

---
 rtl/noc_fc_pkg.sv | 43 ++++
 rtl/noc_rr_arbiter.sv | 55 +++++
 rtl/noc_vc_credit_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_noc_vc_credit_scheduler.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_fc_pkg.sv
// ---------------------------------------------------------------------------
// noc_fc_pkg
// Shared types and defaults for the NoC flow-control slice. The VC
// scheduler, the flow-control stage and the link block all use it.
//
// Contents:
//   DEFAULT_*     default sizing of the router build
//   vc_id_t       virtual-channel identifier
//   credit_t      downstream credit counter
//   flit_t        flit as it travels between scheduler, flow control and link
//   lock_state_e  wormhole lock state of an output port
// ---------------------------------------------------------------------------
package noc_fc_pkg;

  localparam int DEFAULT_VC_NUM       = 4;
  localparam int DEFAULT_DATA_WIDTH   = 64;
  localparam int DEFAULT_CREDIT_WIDTH = 4;
  localparam int DEFAULT_MAX_CREDIT   = 8;
  localparam int VC_ID_WIDTH          = $clog2(DEFAULT_VC_NUM);

  typedef logic [VC_ID_WIDTH-1:0]          vc_id_t;
  typedef logic [DEFAULT_CREDIT_WIDTH-1:0] credit_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    vc_id_t                        vc;
    logic                          last;
  } flit_t;

  // A port is either free for arbitration or held by one VC until that VC's
  // tail flit has been accepted.
  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Successor of a VC id; it wraps naturally because the VC count is a
  // power of two.
  function automatic vc_id_t next_vc(input vc_id_t v);
    return v + vc_id_t'(1);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_rr_arbiter
// N-way round-robin arbiter that can be locked to one requester. The
// switch allocator reuses it.
//
// Ports:
//   i_enable   arbitration allowed this cycle (no grant when low)
//   i_req      request vector, one bit per requester
//   i_ptr      highest-priority requester; the search goes upward from here
//   i_locked   only i_lock_id may be granted
//   i_lock_id  requester that holds the lock
//   o_grant    one-hot grant, or zero
// ---------------------------------------------------------------------------
module noc_rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           i_enable,
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_locked,
  input  logic [IDW-1:0] i_lock_id,
  output logic [N-1:0]   o_grant
);

  logic [IDW-1:0] w_idx;
  logic           w_found;

  // While the lock is held, only the lock owner can win, and only if it is
  // requesting. The other requesters wait even when the link is idle.
  // When the lock is free, the search goes upward from the pointer. The index
  // sum overflows back to zero because N is a power of two, so the wrap
  // needs no explicit modulo.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (i_enable) begin
      if (i_locked) begin
        if (i_req[i_lock_id]) begin
          o_grant[i_lock_id] = 1'b1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          w_idx = i_ptr + IDW'(k);
          if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/noc_vc_credit_scheduler.sv
// ---------------------------------------------------------------------------
// noc_vc_credit_scheduler
// Per-output-port VC scheduler. VC_NUM input VC queues share one output
// link under round-robin arbitration. A flit goes out only when its VC
// holds a downstream credit. A wormhole packet keeps the link until its
// tail flit has been accepted.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   vc_valid        flit pending, per VC
//   vc_data         flit payload per VC, VC v at [v*DATA_WIDTH +: DATA_WIDTH]
//   vc_last         pending flit is the packet tail, per VC
//   vc_ready        one-hot (or zero) accept strobe back to the VC buffers
//   out_valid/data/vc/last  registered output flit
//   out_ready       link accepts the output flit
//   credit_return   downstream freed one buffer, per VC
//   credit_count    live credit counters, VC v at [v*CREDIT_WIDTH +: CREDIT_WIDTH]
//   credit_err      sticky: a credit came back to a counter that was already full
// ---------------------------------------------------------------------------
module noc_vc_credit_scheduler
  import noc_fc_pkg::*;
#(
  parameter  int VC_NUM       = DEFAULT_VC_NUM,
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int CREDIT_WIDTH = DEFAULT_CREDIT_WIDTH,
  parameter  int MAX_CREDIT   = DEFAULT_MAX_CREDIT,
  localparam int VCW          = $clog2(VC_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [VC_NUM-1:0]              vc_valid,
  input  logic [VC_NUM*DATA_WIDTH-1:0]   vc_data,
  input  logic [VC_NUM-1:0]              vc_last,
  output logic [VC_NUM-1:0]              vc_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [VCW-1:0]                 out_vc,
  output logic                           out_last,
  input  logic                           out_ready,
  input  logic [VC_NUM-1:0]              credit_return,
  output logic [VC_NUM*CREDIT_WIDTH-1:0] credit_count,
  output logic                           credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] r_credit [VC_NUM];
  logic [VCW-1:0]          r_ptr;
  logic [VCW-1:0]          r_lock_vc;
  lock_state_e             r_lock_state;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [VCW-1:0]          r_out_vc;
  logic                    r_out_last;
  logic                    r_credit_err;

  logic                    w_slot_free;
  logic                    w_arb_enable;
  logic [VC_NUM-1:0]       w_elig;
  logic [VC_NUM-1:0]       w_grant;
  logic                    w_accept;
  logic [VCW-1:0]          w_acc_vc;
  logic [DATA_WIDTH-1:0]   w_acc_data;
  logic                    w_acc_last;

  // A VC may compete only when it has a flit and at least one downstream
  // buffer is free for it.
  always_comb begin
    w_elig = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_elig[v] = vc_valid[v] && (r_credit[v] != '0);
    end
  end

  // The output register can take a new flit when it is empty or is being
  // drained this cycle. Arbitration is disabled while reset is held, so the
  // VC buffers never see a ready strobe during reset.
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_arb_enable = w_slot_free && rst_n;

  noc_rr_arbiter #(
    .N (VC_NUM)
  ) u_arb (
    .i_enable  (w_arb_enable),
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .i_locked  (r_lock_state == LOCK_HELD),
    .i_lock_id (r_lock_vc),
    .o_grant   (w_grant)
  );

  // A grant goes only to an eligible VC, which is already valid, so every
  // grant is an accept.
  assign vc_ready = w_grant;
  assign w_accept = |w_grant;

  // Select the id, payload and tail bit of the granted VC. The grant is
  // one-hot, so at most one branch fires.
  always_comb begin
    w_acc_vc   = '0;
    w_acc_data = '0;
    w_acc_last = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_grant[v]) begin
        w_acc_vc   = VCW'(v);
        w_acc_data = vc_data[v*DATA_WIDTH +: DATA_WIDTH];
        w_acc_last = vc_last[v];
      end
    end
  end

  // Output register. A new accept overwrites the slot; this is legal because
  // an accept happens only when the slot is empty or being drained. A stalled
  // flit (valid with no ready) holds every field. On reset the in-flight
  // flit is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_vc    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_data;
      r_out_vc    <= w_acc_vc;
      r_out_last  <= w_acc_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer and wormhole lock. The pointer advances only past
  // a VC whose packet has completed, and a body flit locks the port to its
  // VC. A single-flit packet advances the pointer and never takes the lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_lock_vc    <= '0;
      r_lock_state <= LOCK_IDLE;
    end else if (w_accept) begin
      if (w_acc_last) begin
        r_ptr        <= w_acc_vc + VCW'(1);
        r_lock_state <= LOCK_IDLE;
      end else begin
        r_lock_vc    <= w_acc_vc;
        r_lock_state <= LOCK_HELD;
      end
    end
  end

  // Credit counters. When an accept and a returned credit coincide, they
  // cancel. A credit returned to a full counter means the downstream side
  // lost count. The counter saturates and the sticky error flag is raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_NUM; v++) begin
        r_credit[v] <= CREDIT_MAX;
      end
      r_credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        case ({w_grant[v], credit_return[v]})
          2'b10: r_credit[v] <= r_credit[v] - CREDIT_ONE;
          2'b01: begin
            if (r_credit[v] == CREDIT_MAX) begin
              r_credit_err <= 1'b1;
            end else begin
              r_credit[v] <= r_credit[v] + CREDIT_ONE;
            end
          end
          default: r_credit[v] <= r_credit[v];
        endcase
      end
    end
  end

  // Pack the counters into the flat status vector.
  always_comb begin
    credit_count = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      credit_count[v*CREDIT_WIDTH +: CREDIT_WIDTH] = r_credit[v];
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_vc     = r_out_vc;
  assign out_last   = r_out_last;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_vc_credit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_noc_vc_credit_scheduler
// Self-checking bench for noc_vc_credit_scheduler. Each scenario task drives
// the VC inputs, queues the flits it expects on the link, and checks the
// strobes and counters inline. A negedge monitor pops the queue whenever the
// link consumes a flit.
// ---------------------------------------------------------------------------
module tb_noc_vc_credit_scheduler;

  localparam int VCN  = 4;
  localparam int DW   = 64;
  localparam int CW   = 4;
  localparam int MAXC = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [VCN-1:0]    vc_valid;
  logic [VCN*DW-1:0] vc_data;
  logic [VCN-1:0]    vc_last;
  logic [VCN-1:0]    vc_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_vc;
  logic              out_last;
  logic              out_ready;
  logic [VCN-1:0]    credit_return;
  logic [VCN*CW-1:0] credit_count;
  logic              credit_err;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    vc;
    logic          last;
  } exp_t;

  exp_t expQ[$];
  int   nVectors     = 0;
  int   nMiscompares = 0;

  noc_vc_credit_scheduler #(
    .VC_NUM       (VCN),
    .DATA_WIDTH   (DW),
    .CREDIT_WIDTH (CW),
    .MAX_CREDIT   (MAXC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vc_valid      (vc_valid),
    .vc_data       (vc_data),
    .vc_last       (vc_last),
    .vc_ready      (vc_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_vc        (out_vc),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .credit_return (credit_return),
    .credit_count  (credit_count),
    .credit_err    (credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkData(input int v, input int k);
    return {8'(v), 24'h5A5A5A, 32'(k)};
  endfunction

  function automatic logic [CW-1:0] creditOf(input int v);
    return credit_count[v*CW +: CW];
  endfunction

  // Inputs change 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setVc(input int v, input logic valid, input int k, input logic last);
    vc_valid[v]          = valid;
    vc_data[v*DW +: DW]  = mkData(v, k);
    vc_last[v]           = last;
  endtask

  task automatic pushExp(input int v, input int k, input logic last);
    exp_t e;
    e.data = mkData(v, k);
    e.vc   = 2'(v);
    e.last = last;
    expQ.push_back(e);
  endtask

  // Scoreboard: a flit is consumed at the next rising edge whenever
  // out_valid and out_ready are both high during the cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      nVectors++;
      if (expQ.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL sb_unexpected flit got vc=%0d data=%h last=%b want none",
                 out_vc, out_data, out_last);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if ({out_data, out_vc, out_last} !== {e.data, e.vc, e.last}) begin
          nMiscompares++;
          $display("[TB] FAIL sb_flit got vc=%0d data=%h last=%b want vc=%0d data=%h last=%b",
                   out_vc, out_data, out_last, e.vc, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int v = 0; v < VCN; v++) setVc(v, 1'b1, 0, 1'b1);
    repeat (2) stepCycle();
    #2;
    nVectors++;
    if (vc_ready !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL reset_ready got %b want 0000", vc_ready);
    end
    nVectors++;
    if (out_valid !== 1'b0 || credit_err !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_flags got valid=%b err=%b want 0 0", out_valid, credit_err);
    end
    for (int v = 0; v < VCN; v++) begin
      nVectors++;
      if (creditOf(v) !== 4'(MAXC)) begin
        nMiscompares++;
        $display("[TB] FAIL reset_credit vc%0d got %0d want %0d", v, creditOf(v), MAXC);
      end
    end
    vc_valid = '0;
    rst_n    = 1'b1;
    stepCycle();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      for (int v = 0; v < VCN; v++) setVc(v, 1'b1, k, 1'b1);
      pushExp(k % VCN, k, 1'b1);
      #2;
      nVectors++;
      if (vc_ready !== 4'(1 << (k % VCN))) begin
        nMiscompares++;
        $display("[TB] FAIL rr_ready k=%0d got %b want %b", k, vc_ready, 4'(1 << (k % VCN)));
      end
      stepCycle();
      if (k < VCN) begin
        nVectors++;
        if (creditOf(k) !== 4'(MAXC - 1)) begin
          nMiscompares++;
          $display("[TB] FAIL rr_credit vc%0d got %0d want %0d", k, creditOf(k), MAXC - 1);
        end
      end
    end
    vc_valid = '0;
    repeat (2) stepCycle();
    nVectors++;
    if (credit_count !== {4'd7, 4'd7, 4'd7, 4'd6}) begin
      nMiscompares++;
      $display("[TB] FAIL rr_credit_all got %h want 7776", credit_count);
    end
  endtask

  task automatic test_wormhole_lock();
    // Pointer sits at VC1. VC2 has a single-flit packet waiting throughout.
    logic [VCN-1:0] wantReady [5];
    logic           vc1Valid  [5];
    logic           vc1Last   [5];
    wantReady = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
    vc1Valid  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vc1Last   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pushExp(1, 10, 1'b0);
    pushExp(1, 11, 1'b0);
    pushExp(1, 12, 1'b1);
    pushExp(2, 20, 1'b1);
    for (int c = 0; c < 5; c++) begin
      setVc(1, vc1Valid[c], (c < 2) ? 10 : 9 + c, vc1Last[c]);
      setVc(2, 1'b1, 20, 1'b1);
      #2;
      nVectors++;
      if (vc_ready !== wantReady[c]) begin
        nMiscompares++;
        $display("[TB] FAIL lock_ready cycle=%0d got %b want %b", c, vc_ready, wantReady[c]);
      end
      stepCycle();
    end
    vc_valid = '0;
    repeat (2) stepCycle();
    nVectors++;
    if (creditOf(1) !== 4'd4 || creditOf(2) !== 4'd6) begin
      nMiscompares++;
      $display("[TB] FAIL lock_credit got vc1=%0d vc2=%0d want 4 6", creditOf(1), creditOf(2));
    end
  endtask

  task automatic test_credit_exhaust();
    repeat (2) begin
      credit_return = 4'b0001;
      stepCycle();
    end
    credit_return = '0;
    nVectors++;
    if (creditOf(0) !== 4'd8 || credit_err !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL exh_refill got cnt=%0d err=%b want 8 0", creditOf(0), credit_err);
    end
    for (int k = 0; k < MAXC; k++) begin
      setVc(0, 1'b1, 100 + k, 1'b1);
      pushExp(0, 100 + k, 1'b1);
      #2;
      nVectors++;
      if (vc_ready !== 4'b0001) begin
        nMiscompares++;
        $display("[TB] FAIL exh_ready k=%0d got %b want 0001", k, vc_ready);
      end
      stepCycle();
    end
    setVc(0, 1'b1, 150, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0000 || creditOf(0) !== 4'd0) begin
      nMiscompares++;
      $display("[TB] FAIL exh_block got ready=%b cnt=%0d want 0000 0", vc_ready, creditOf(0));
    end
    stepCycle();
    credit_return = 4'b0001;
    #2;
    nVectors++;
    if (vc_ready !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL exh_ret_cycle got ready=%b want 0000", vc_ready);
    end
    stepCycle();
    credit_return = '0;
    setVc(0, 1'b1, 200, 1'b1);
    pushExp(0, 200, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0001 || creditOf(0) !== 4'd1) begin
      nMiscompares++;
      $display("[TB] FAIL exh_one_more got ready=%b cnt=%0d want 0001 1", vc_ready, creditOf(0));
    end
    stepCycle();
    setVc(0, 1'b1, 201, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0000 || creditOf(0) !== 4'd0) begin
      nMiscompares++;
      $display("[TB] FAIL exh_reblock got ready=%b cnt=%0d want 0000 0", vc_ready, creditOf(0));
    end
    vc_valid = '0;
    repeat (2) stepCycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    setVc(3, 1'b1, 300, 1'b1);
    pushExp(3, 300, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b1000) begin
      nMiscompares++;
      $display("[TB] FAIL bp_first got %b want 1000", vc_ready);
    end
    stepCycle();
    setVc(3, 1'b1, 301, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #2;
      nVectors++;
      if (vc_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== mkData(3, 300) ||
          out_vc !== 2'd3 || out_last !== 1'b1 || creditOf(3) !== 4'd6) begin
        nMiscompares++;
        $display("[TB] FAIL bp_hold c=%0d got ready=%b v=%b d=%h vc=%0d cnt=%0d want 0000 1 %h 3 6",
                 c, vc_ready, out_valid, out_data, out_vc, creditOf(3), mkData(3, 300));
      end
      stepCycle();
    end
    out_ready = 1'b1;
    pushExp(3, 301, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b1000) begin
      nMiscompares++;
      $display("[TB] FAIL bp_release got %b want 1000", vc_ready);
    end
    stepCycle();
    vc_valid = '0;
    repeat (2) stepCycle();
    nVectors++;
    if (creditOf(3) !== 4'd5) begin
      nMiscompares++;
      $display("[TB] FAIL bp_credit got %0d want 5", creditOf(3));
    end
  endtask

  task automatic test_credit_simul();
    for (int k = 0; k < 2; k++) begin
      setVc(2, 1'b1, 400 + k, 1'b1);
      pushExp(2, 400 + k, 1'b1);
      #2;
      nVectors++;
      if (vc_ready !== 4'b0100) begin
        nMiscompares++;
        $display("[TB] FAIL simul_pre k=%0d got %b want 0100", k, vc_ready);
      end
      stepCycle();
    end
    nVectors++;
    if (creditOf(2) !== 4'd4) begin
      nMiscompares++;
      $display("[TB] FAIL simul_start got %0d want 4", creditOf(2));
    end
    setVc(2, 1'b1, 410, 1'b1);
    credit_return = 4'b0100;
    pushExp(2, 410, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0100) begin
      nMiscompares++;
      $display("[TB] FAIL simul_ready got %b want 0100", vc_ready);
    end
    stepCycle();
    credit_return = '0;
    vc_valid      = '0;
    nVectors++;
    if (creditOf(2) !== 4'd4) begin
      nMiscompares++;
      $display("[TB] FAIL simul_credit got %0d want 4", creditOf(2));
    end
    stepCycle();
  endtask

  task automatic test_overflow_and_reset();
    repeat (4) begin
      credit_return = 4'b0011;
      stepCycle();
    end
    credit_return = '0;
    nVectors++;
    if (creditOf(1) !== 4'd8 || creditOf(0) !== 4'd4 || credit_err !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL ovf_fill got vc1=%0d vc0=%0d err=%b want 8 4 0",
               creditOf(1), creditOf(0), credit_err);
    end
    credit_return = 4'b0010;
    stepCycle();
    credit_return = '0;
    nVectors++;
    if (creditOf(1) !== 4'd8 || credit_err !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL ovf_flag got cnt=%0d err=%b want 8 1", creditOf(1), credit_err);
    end
    repeat (3) stepCycle();
    nVectors++;
    if (credit_err !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL ovf_sticky got %b want 1", credit_err);
    end
    // VC0 body flit stalls on the link, then the port stays locked to VC0.
    out_ready = 1'b0;
    setVc(0, 1'b1, 500, 1'b0);
    pushExp(0, 500, 1'b0);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0001) begin
      nMiscompares++;
      $display("[TB] FAIL rst_body got %b want 0001", vc_ready);
    end
    stepCycle();
    out_ready = 1'b1;
    vc_valid  = '0;
    setVc(1, 1'b1, 600, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL rst_locked got %b want 0000", vc_ready);
    end
    stepCycle();
    out_ready = 1'b0;
    setVc(0, 1'b1, 501, 1'b0);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0001) begin
      nMiscompares++;
      $display("[TB] FAIL rst_body2 got %b want 0001", vc_ready);
    end
    stepCycle();
    // Flit 501 is in flight and gets dropped by the reset.
    rst_n       = 1'b0;
    vc_valid[0] = 1'b0;
    #2;
    nVectors++;
    if (vc_ready !== 4'b0000) begin
      nMiscompares++;
      $display("[TB] FAIL rst_ready got %b want 0000", vc_ready);
    end
    stepCycle();
    nVectors++;
    if (out_valid !== 1'b0 || credit_err !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL rst_flags got valid=%b err=%b want 0 0", out_valid, credit_err);
    end
    for (int v = 0; v < VCN; v++) begin
      nVectors++;
      if (creditOf(v) !== 4'(MAXC)) begin
        nMiscompares++;
        $display("[TB] FAIL rst_credit vc%0d got %0d want %0d", v, creditOf(v), MAXC);
      end
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    pushExp(1, 600, 1'b1);
    #2;
    nVectors++;
    if (vc_ready !== 4'b0010) begin
      nMiscompares++;
      $display("[TB] FAIL rst_unlock got %b want 0010", vc_ready);
    end
    stepCycle();
    vc_valid = '0;
    repeat (3) stepCycle();
  endtask

  initial begin
    rst_n         = 1'b0;
    vc_valid      = '0;
    vc_data       = '0;
    vc_last       = '0;
    out_ready     = 1'b1;
    credit_return = '0;

    test_reset();
    test_round_robin();
    test_wormhole_lock();
    test_credit_exhaust();
    test_backpressure();
    test_credit_simul();
    test_overflow_and_reset();

    nVectors++;
    if (expQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL sb_drain got %0d pending want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
